// File: rtl/sram_controller.sv
// Memory-stage responder: runs one 32-bit access as two 16-bit halves on an async SRAM.
// Latency 2*HALF_CYCLES+1 cycles of ready low per request; requests are latched, so input changes mid-access are ignored.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = (HALF_CYCLES > 2) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [16:0]   word_q;
  logic [31:0]   wdata_q;
  logic          op_wr_q;
  logic [15:0]   dq_q, dq_n;
  logic          dq_oe, oe_n;
  logic [17:0]   addr_n;
  logic          we_n_n;
  logic          hi_n;

  logic [31:0]   offs;
  logic          req;
  logic [16:0]   eff_word;
  logic [31:0]   eff_wdata;
  logic          eff_wr;
  logic          unused_offs;

  assign req         = wr_en | rd_en;
  assign offs        = address - 32'(BASE_ADDR);
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  // Outputs are registered, so the first ACC_LO cycle must be computed from the live inputs.
  assign eff_word  = (state == IDLE) ? offs[18:2] : word_q;
  assign eff_wdata = (state == IDLE) ? write_data : wdata_q;
  assign eff_wr    = (state == IDLE) ? wr_en      : op_wr_q;

  assign SRAM_DQ   = dq_oe ? dq_q : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready   = 1'b0;
    addr_n  = SRAM_ADDR;
    we_n_n  = 1'b1;
    oe_n    = 1'b0;
    dq_n    = dq_q;
    hi_n    = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_n = ACC_LO;
          cnt_n   = '0;
        end
      end
      ACC_LO: begin
        if (cnt == LAST) begin
          state_n = ACC_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ACC_HI: begin
        if (cnt == LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Last cycle of each half keeps address/data stable with the strobe released.
    if (state_n == ACC_LO || state_n == ACC_HI) begin
      hi_n   = (state_n == ACC_HI);
      addr_n = {eff_word, hi_n};
      we_n_n = ~(eff_wr && (cnt_n != LAST));
      oe_n   = eff_wr;
      dq_n   = hi_n ? eff_wdata[31:16] : eff_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_q      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      SRAM_ADDR <= addr_n;
      SRAM_WE_N <= we_n_n;
      dq_oe     <= oe_n;
      dq_q      <= dq_n;
      if (state == IDLE && req) begin
        word_q  <= offs[18:2];
        wdata_q <= write_data;
        op_wr_q <= wr_en;
      end
      if (!op_wr_q && cnt == LAST) begin
        if (state == ACC_LO) read_data[15:0]  <= SRAM_DQ;
        if (state == ACC_HI) read_data[31:16] <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM behavioural model plus a word-level reference of memory and load results.
module tb_sram_controller;

  localparam int H    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  tri0  [15:0] sram_dq;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;

  logic        drv;
  logic [15:0] drv_val;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sram_mem [logic [17:0]];
  logic [15:0] ref_mem  [logic [17:0]];
  logic [31:0] ref_rd;

  always #5 clk = ~clk;

  assign sram_dq = drv ? drv_val : 16'hzzzz;

  sram_controller #(.BASE_ADDR(BASE), .HALF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // The SRAM stores whatever is on the bus while the strobe is low.
  always @(negedge clk) if (we_n === 1'b0) sram_mem[sram_addr] = sram_dq;

  function automatic logic [15:0] sram_peek(input logic [17:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 16'h0;
  endfunction

  function automatic logic [15:0] ref_peek(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 0; rd_en = 0; drv = 0;
      @(negedge clk);
      chk("idle_ready", ready, 1);
      chk("idle_rdata", read_data, ref_rd);
      chk("idle_we_n", we_n, 1);
      chk("idle_dq", sram_dq, 0);
    end
  endtask

  // One access from its IDLE request cycle through DONE, checking every bus cycle.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input bit perturb, input bit hold, input int rst_at);
    logic [31:0] word;
    logic [17:0] lo, hi, ea;
    logic [15:0] half;
    logic [31:0] exp_rd;
    int c;
    word   = (a - BASE) >> 2;
    lo     = {word[16:0], 1'b0};
    hi     = {word[16:0], 1'b1};
    exp_rd = wr ? ref_rd : {ref_peek(hi), ref_peek(lo)};

    @(posedge clk); #1;
    rst = 1; wr_en = wr; rd_en = rd; address = a; write_data = d; drv = 0;
    @(negedge clk);
    chk("req_ready", ready, 0);

    for (int k = 1; k <= 2*H; k++) begin
      @(posedge clk); #1;
      c  = (k - 1) % H;
      ea = (k <= H) ? lo : hi;
      if (perturb && k == 1) begin
        address    = $urandom;
        write_data = $urandom;
      end
      if (k == rst_at) rst = 0;
      drv     = !wr && (c == H-1);
      drv_val = sram_peek(ea);
      @(negedge clk);
      chk("acc_ready", ready, 0);
      chk("acc_addr", sram_addr, ea);
      chk("acc_we_n", we_n, (wr && c <= H-2) ? 0 : 1);
      half = (k <= H) ? d[15:0] : d[31:16];
      if (wr) chk("acc_dq_wr", sram_dq, half);
      else if (!drv) chk("acc_dq_z", sram_dq, 0);
      if (k == rst_at) begin
        @(posedge clk); #1;
        rst = 1; wr_en = 0; rd_en = 0; drv = 0; ref_rd = 0;
        @(negedge clk);
        chk("mrst_rdata", read_data, 0);
        chk("mrst_ready", ready, 1);
        chk("mrst_we_n", we_n, 1);
        chk("mrst_dq", sram_dq, 0);
        return;
      end
    end

    @(posedge clk); #1;
    drv = 0;
    if (!hold) begin wr_en = 0; rd_en = 0; end
    if (wr) begin
      ref_mem[lo] = d[15:0];
      ref_mem[hi] = d[31:16];
    end else begin
      ref_rd = exp_rd;
    end
    @(negedge clk);
    chk("done_ready", ready, 1);
    chk("done_rdata", read_data, ref_rd);
    chk("done_we_n", we_n, 1);
    if (wr) begin
      chk("sram_lo", sram_peek(lo), ref_peek(lo));
      chk("sram_hi", sram_peek(hi), ref_peek(hi));
    end
  endtask

  initial begin
    int op;
    logic [31:0] a, d;
    rst = 0; wr_en = 0; rd_en = 1; address = BASE; write_data = 0;
    drv = 0; drv_val = 0; ref_rd = 0;

    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_rdata", read_data, 0);
      chk("rst_we_n", we_n, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_dq", sram_dq, 0);
      chk("rst_ready", ready, 0);
    end

    // Release with rd_en held: a read of unwritten memory starts at once.
    access(0, 1, BASE, 0, 0, 0, 0);
    access(1, 0, BASE + 8, 32'hDEADBEEF, 0, 0, 0);
    idle(1);
    access(0, 1, BASE + 8, 32'h0, 0, 0, 0);
    chk("readback", read_data, 32'hDEADBEEF);
    idle(3);
    access(1, 1, BASE, 32'h12345678, 0, 0, 0);
    chk("both_lo", sram_peek(18'd0), 32'h5678);
    chk("both_hi", sram_peek(18'd1), 32'h1234);
    idle(1);

    // Inputs change during ACC_LO; request held through DONE starts a second access.
    access(1, 0, BASE + 16, 32'hA5A5C3C3, 1, 1, 0);
    access(1, 0, address, write_data, 0, 0, 0);
    access(0, 1, BASE + 16, 32'h0, 1, 0, 0);
    idle(1);

    access(0, 1, BASE + 8, 32'h0, 0, 0, H + 1);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + $urandom_range(0, 63);
      d  = $urandom;
      access(op != 1, op != 0, a, d, $urandom_range(0, 1) == 1, 0, 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage responder for the EX/MEM pipeline register. It consumes the registered memory request (read/write enables, ALU-computed address, store value), executes a 32-bit access on a 16-bit-wide external asynchronous SRAM as two half-word transfers, and drives `ready` back so the pipeline registers hold (`freeze = ~ready`) until the access finishes. It sits between the EX/MEM register outputs and the MEM/WB register inputs.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `HALF_CYCLES`, 2: clock cycles spent on each 16-bit half; minimum 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  store request (EX/MEM `MEM_W_EN`).
- `rd_en`  in  1  load request (EX/MEM `MEM_R_EN`).
- `address`  in  32  byte address (EX/MEM `ALU_result`).
- `write_data`  in  32  store value (EX/MEM `ST_val`).
- `read_data`  out  32  last completed load value.
- `ready`  out  1  high when no access is pending or the access completes this cycle.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_WE_N`  out  1  SRAM write strobe, active-low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied 0.

## Operation
- States: IDLE, ACC_LO, ACC_HI, DONE. A cycle counter runs 0..HALF_CYCLES-1 inside each ACC state.
- IDLE: if `wr_en` or `rd_en` is high, latch `address`, `write_data` and the operation type, then go to ACC_LO. Write has priority when both are high; the access is a write, and `read_data` is not updated.
- Address map: `word = (address - BASE_ADDR) >> 2`. ACC_LO drives `SRAM_ADDR = {word[16:0],1'b0}`, and ACC_HI drives `{word[16:0],1'b1}`. Higher bits are truncated and are not checked.
- Write: ACC_LO drives `write_data[15:0]` onto `SRAM_DQ`, and ACC_HI drives `[31:16]`. `SRAM_WE_N` is 0 for counter values 0..HALF_CYCLES-2 of each half, and 1 on the last cycle, which is the address/data hold cycle.
- Read: `SRAM_DQ` is high-Z and `SRAM_WE_N` is 1. On the last cycle of ACC_LO, sample into `read_data[15:0]`. On the last cycle of ACC_HI, sample into `read_data[31:16]`.
- `SRAM_DQ` is high-Z in every state except write ACC_LO/ACC_HI.
- After the last ACC_HI cycle, go to DONE. DONE lasts one cycle and always returns to IDLE. A request that is still present on the following cycle is treated as a new access.
- Requests that change or drop during ACC_LO/ACC_HI are ignored, because the latched values are used. An access never aborts except on reset.
- `ready` is combinational:
  - In IDLE, `ready = ~(wr_en | rd_en)`.
  - In ACC_LO and ACC_HI, `ready` is 0.
  - In DONE, `ready` is 1.

## Timing
- Reset (`rst`=0 at a rising edge) sets:
  - state IDLE, counter 0;
  - `read_data` = 0;
  - `SRAM_WE_N` = 1, `SRAM_ADDR` = 0, `SRAM_DQ` high-Z.
- `ready` after reset follows the IDLE rule.
- Reset asserted mid-access takes effect on the next edge: the state returns to IDLE and the bus is released. The partial write may be left in the SRAM. A partially loaded `read_data` is cleared to 0.
- Request first seen in IDLE at cycle 0:
  - ACC_LO occupies cycles 1..H.
  - ACC_HI occupies cycles H+1..2H.
  - DONE is cycle 2H+1.
- `ready` is low for cycles 0..2H, which is 2H+1 cycles of freeze (5 for H=2). It is high in cycle 2H+1.
- `read_data` holds the full new word from the start of DONE and holds it until the next read completes.
- `SRAM_ADDR`, `SRAM_WE_N` and the DQ drive enable are registered, so they change only on clock edges.
- Back-to-back requests cost 2H+2 cycles each: there is always one DONE cycle and one IDLE cycle between accesses.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `rd_en`=1. Expect `read_data`=0, `SRAM_WE_N`=1 and `SRAM_DQ`=Z; `ready`=0 after release. Expect no access while `rst` is low.
- Write: `wr_en`=1, `address`=1024+8, `write_data`=0xDEADBEEF, H=2. Expect `SRAM_ADDR`=4 with DQ=0xBEEF, then 5 with DQ=0xDEAD. `SRAM_WE_N` is low for 1 cycle per half. `ready` is low for 5 cycles, then high for 1.
- Read-back: `rd_en`=1 with the same address against an SRAM model. Expect `read_data`=0xDEADBEEF in DONE, DQ never driven, and `read_data` stable afterwards with `rd_en`=0.
- Simultaneous: `wr_en`=`rd_en`=1, `address`=1024, data 0x12345678. Expect a write of 0x5678 to address 0 and 0x1234 to address 1, with `read_data` unchanged.
- Request change mid-access: change `address`/`write_data` during ACC_LO. Expect the SRAM to receive the originally latched values. Then keep the request high through DONE and expect a second full access to start in IDLE.
- Reset mid-access: assert `rst`=0 during ACC_HI of a read. Expect IDLE on the next edge, `read_data`=0, and the bus released.
